// File: rtl/turing_pkg.sv
// Shared constants for the tape-engine job scheduler: FSM encoding, default
// sizes and the width helper used for id and counter widths.
package turing_pkg;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_LOAD = 2'b01;
   localparam logic [1:0] S_RUN  = 2'b10;
   localparam logic [1:0] S_RESP = 2'b11;

   localparam int TAPE_W_DEF  = 10;
   localparam int TIMEOUT_DEF = 64;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/turing_job_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or above ptr,
// wrapping, wins.
module rr_arbiter import turing_pkg::*; #(
   parameter int NREQ = 4,
   parameter int IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);

   logic [IDW-1:0] idx;

   // Walk from lowest to highest priority so the last hit is the winner.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      idx    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = IDW'((int'(ptr) + i) % NREQ);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_id   = idx;
         end
      end
   end

endmodule

// File: rtl/turing_job_sched.sv
// Round-robin front end that time-shares one tape engine among NREQ
// requesters, supervises each run with a timeout and returns tagged results.
module turing_job_sched import turing_pkg::*; #(
   parameter int NREQ    = 4,
   parameter int TAPE_W  = TAPE_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*TAPE_W-1:0]   req_tape,
   output logic [NREQ-1:0]          req_ready,
   output logic                     eng_load,
   output logic [TAPE_W-1:0]        eng_tape,
   output logic                     eng_abort,
   input  logic                     eng_halt,
   input  logic [TAPE_W-1:0]        eng_result,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [clog2(NREQ)-1:0]   rsp_id,
   output logic [TAPE_W-1:0]        rsp_tape,
   output logic                     rsp_timeout,
   output logic [15:0]              jobs_done,
   output logic [15:0]              jobs_aborted
);

   localparam int IDW = clog2(NREQ);
   localparam int CW  = clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [1:0]        state;
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    cap_id;
   logic [IDW-1:0]    gnt_id;
   logic [TAPE_W-1:0] cap_tape;
   logic [TAPE_W-1:0] sel_tape;
   logic [CW-1:0]     cnt;
   logic [NREQ-1:0]   gnt;
   logic              hs;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req_ready = (state == S_IDLE) ? gnt : '0;
   assign hs        = |(req_valid & req_ready);
   // Gated by eng_halt in the same cycle so a halt on the last RUN cycle wins.
   assign eng_abort = (state == S_RUN) && (cnt == CNT_LAST) && !eng_halt;

   always_comb begin
      sel_tape = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) sel_tape = req_tape[i*TAPE_W +: TAPE_W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         cap_id       <= '0;
         cap_tape     <= '0;
         cnt          <= '0;
         eng_load     <= 1'b0;
         eng_tape     <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_tape     <= '0;
         rsp_timeout  <= 1'b0;
         jobs_done    <= '0;
         jobs_aborted <= '0;
      end else begin
         eng_load <= 1'b0;
         eng_tape <= '0;
         case (state)
            S_IDLE: begin
               if (hs) begin
                  cap_tape <= sel_tape;
                  cap_id   <= gnt_id;
                  eng_load <= 1'b1;
                  eng_tape <= sel_tape;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               cnt   <= '0;
               state <= S_RUN;
            end
            S_RUN: begin
               cnt <= cnt + CW'(1);
               if (eng_halt) begin
                  rsp_tape    <= eng_result;
                  rsp_timeout <= 1'b0;
                  rsp_id      <= cap_id;
                  rsp_valid   <= 1'b1;
                  state       <= S_RESP;
               end else if (cnt == CNT_LAST) begin
                  rsp_tape    <= cap_tape;
                  rsp_timeout <= 1'b1;
                  rsp_id      <= cap_id;
                  rsp_valid   <= 1'b1;
                  state       <= S_RESP;
               end
            end
            default: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  jobs_done <= jobs_done + 16'd1;
                  if (rsp_timeout) jobs_aborted <= jobs_aborted + 16'd1;
                  rr_ptr <= (cap_id == IDW'(NREQ - 1)) ? '0 : cap_id + IDW'(1);
                  state  <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_turing_job_sched.sv
// Bench for turing_job_sched: two instances (TIMEOUT 64 and 8), a job-level
// reference model checked every cycle, and directed scenarios with literals.
module tb_turing_job_sched;

   localparam int NREQ = 4;
   localparam int TW   = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    rv  [2];
   logic [NREQ*TW-1:0] rt  [2];
   logic               hl  [2];
   logic [TW-1:0]      res [2];
   logic               rr  [2];
   logic [NREQ-1:0]    rdy [2];
   logic               eld [2];
   logic [TW-1:0]      etp [2];
   logic               eab [2];
   logic               rsv [2];
   logic [1:0]         rid [2];
   logic [TW-1:0]      rtp [2];
   logic               rto [2];
   logic [15:0]        jd  [2];
   logic [15:0]        ja  [2];

   int checks   = 0;
   int failures = 0;

   turing_job_sched #(.NREQ(NREQ), .TAPE_W(TW), .TIMEOUT(64)) u_a (
      .clk(clk), .rst(rst), .req_valid(rv[0]), .req_tape(rt[0]), .req_ready(rdy[0]),
      .eng_load(eld[0]), .eng_tape(etp[0]), .eng_abort(eab[0]), .eng_halt(hl[0]),
      .eng_result(res[0]), .rsp_valid(rsv[0]), .rsp_ready(rr[0]), .rsp_id(rid[0]),
      .rsp_tape(rtp[0]), .rsp_timeout(rto[0]), .jobs_done(jd[0]), .jobs_aborted(ja[0]));

   turing_job_sched #(.NREQ(NREQ), .TAPE_W(TW), .TIMEOUT(8)) u_b (
      .clk(clk), .rst(rst), .req_valid(rv[1]), .req_tape(rt[1]), .req_ready(rdy[1]),
      .eng_load(eld[1]), .eng_tape(etp[1]), .eng_abort(eab[1]), .eng_halt(hl[1]),
      .eng_result(res[1]), .rsp_valid(rsv[1]), .rsp_ready(rr[1]), .rsp_id(rid[1]),
      .rsp_tape(rtp[1]), .rsp_timeout(rto[1]), .jobs_done(jd[1]), .jobs_aborted(ja[1]));

   task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, nm, act, exp, $time);
      end
   endtask

   // Lowest valid index at or above p, else lowest valid index below p.
   function automatic logic [NREQ-1:0] arb(input logic [NREQ-1:0] v, input int p);
      logic [NREQ-1:0] g;
      int win;
      g   = '0;
      win = -1;
      for (int j = p; j < NREQ; j++) if (v[j] && win < 0) win = j;
      for (int j = 0; j < p; j++)    if (v[j] && win < 0) win = j;
      if (win >= 0) g[win] = 1'b1;
      return g;
   endfunction

   // Job-level model: age counts cycles since the accepting handshake.
   bit          m_busy [2];
   int          m_age  [2];
   int          m_own  [2];
   logic [TW-1:0] m_tape [2];
   bit          m_pend [2];
   int          m_pid  [2];
   logic [TW-1:0] m_ptape [2];
   bit          m_pto  [2];
   int          m_ptr  [2];
   logic [15:0] m_done [2];
   logic [15:0] m_abt  [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 0; m_age[k] = 0; m_own[k] = 0; m_tape[k] = '0;
         m_pend[k] = 0; m_pid[k] = 0; m_ptape[k] = '0; m_pto[k] = 0;
         m_ptr[k] = 0; m_done[k] = '0; m_abt[k] = '0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            logic [NREQ-1:0] e_rdy;
            bit e_ld, e_ab;
            logic [TW-1:0] e_tp;
            int to_k;
            to_k = (k == 0) ? 64 : 8;
            if (rst) begin
               m_busy[k] = 0; m_pend[k] = 0; m_ptr[k] = 0;
               m_done[k] = '0; m_abt[k] = '0;
               chk(k, "rst_rsp_id", rid[k], 0);
               chk(k, "rst_rsp_tape", rtp[k], 0);
               chk(k, "rst_rsp_timeout", rto[k], 0);
            end
            e_rdy = (!m_busy[k] && !m_pend[k]) ? arb(rv[k], m_ptr[k]) : '0;
            e_ld  = m_busy[k] && m_age[k] == 1;
            e_tp  = e_ld ? m_tape[k] : '0;
            e_ab  = m_busy[k] && m_age[k] >= 2 && (m_age[k] - 1) == to_k && !hl[k];
            chk(k, "req_ready", rdy[k], e_rdy);
            chk(k, "eng_load", eld[k], e_ld);
            chk(k, "eng_tape", etp[k], e_tp);
            chk(k, "eng_abort", eab[k], e_ab);
            chk(k, "rsp_valid", rsv[k], m_pend[k]);
            if (m_pend[k]) begin
               chk(k, "rsp_id", rid[k], m_pid[k]);
               chk(k, "rsp_tape", rtp[k], m_ptape[k]);
               chk(k, "rsp_timeout", rto[k], m_pto[k]);
            end
            chk(k, "jobs_done", jd[k], m_done[k]);
            chk(k, "jobs_aborted", ja[k], m_abt[k]);
            if (!rst) begin
               if (!m_busy[k] && !m_pend[k]) begin
                  if ((rv[k] & e_rdy) != 0) begin
                     for (int i = 0; i < NREQ; i++) if (e_rdy[i]) m_own[k] = i;
                     m_busy[k] = 1;
                     m_age[k]  = 1;
                     m_tape[k] = rt[k][m_own[k]*TW +: TW];
                  end
               end else if (m_busy[k]) begin
                  if (m_age[k] >= 2 && hl[k]) begin
                     m_busy[k] = 0; m_pend[k] = 1; m_pid[k] = m_own[k];
                     m_ptape[k] = res[k]; m_pto[k] = 0;
                  end else if (m_age[k] >= 2 && (m_age[k] - 1) == to_k) begin
                     m_busy[k] = 0; m_pend[k] = 1; m_pid[k] = m_own[k];
                     m_ptape[k] = m_tape[k]; m_pto[k] = 1;
                  end else begin
                     m_age[k]++;
                  end
               end else if (rr[k]) begin
                  m_done[k] = m_done[k] + 16'd1;
                  if (m_pto[k]) m_abt[k] = m_abt[k] + 16'd1;
                  m_ptr[k]  = (m_pid[k] + 1) % NREQ;
                  m_pend[k] = 0;
               end
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_grant(input int k, input logic [NREQ-1:0] mask, output int id);
      id = -1;
      #1;
      for (int c = 0; c < 40; c++) begin
         if ((rdy[k] & mask) != 0) begin
            for (int i = 0; i < NREQ; i++) if (rdy[k][i]) id = i;
            return;
         end
         tick();
      end
      checks++;
      failures++;
      $display("FAIL dut%0d grant_wait: no grant within 40 cycles, mask %0h", k, mask);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      int id;
      for (int k = 0; k < 2; k++) begin
         rv[k] = '0; rt[k] = '0; hl[k] = 1'b0; res[k] = '0; rr[k] = 1'b1;
      end
      tick(2);
      for (int k = 0; k < 2; k++) begin
         chk(k, "reset_rsp_valid", rsv[k], 0);
         chk(k, "reset_eng_load", eld[k], 0);
         chk(k, "reset_jobs_done", jd[k], 0);
      end
      rst = 1'b0;
      tick();

      // Single job: halt in RUN cycle 9
      rv[0] = 4'b0001;
      rt[0][0 +: TW] = 10'b0011110110;
      wait_grant(0, 4'b0001, id);
      chk(0, "t1_grant_id", id, 0);
      tick(); rv[0] = '0;
      chk(0, "t1_eng_load", eld[0], 1);
      chk(0, "t1_eng_tape", etp[0], 10'b0011110110);
      tick(9);
      hl[0] = 1'b1; res[0] = 10'b0011111110;
      tick(); hl[0] = 1'b0;
      chk(0, "t1_rsp_valid", rsv[0], 1);
      chk(0, "t1_rsp_id", rid[0], 0);
      chk(0, "t1_rsp_tape", rtp[0], 10'b0011111110);
      chk(0, "t1_rsp_timeout", rto[0], 0);
      chk(0, "t1_model_tape", m_ptape[0], 10'b0011111110);
      tick();
      chk(0, "t1_jobs_done", jd[0], 1);
      chk(0, "t1_model_done", m_done[0], 1);

      // Round-robin from a fresh pointer with all four requesters pending
      rst = 1'b1; tick(); rst = 1'b0;
      rv[0] = 4'b1111;
      rt[0] = {10'h304, 10'h203, 10'h102, 10'h001};
      for (int j = 0; j < 5; j++) begin
         wait_grant(0, 4'b1111, id);
         chk(0, "t2_grant_order", id, j % 4);
         tick(2);
         tick(2);
         hl[0] = 1'b1; res[0] = 10'(j + 10'h50);
         tick(); hl[0] = 1'b0;
         tick();
      end
      rv[0] = '0;
      chk(0, "t2_jobs_done", jd[0], 5);

      // Timeout on the TIMEOUT=8 instance, requester 2
      rv[1] = 4'b0100;
      rt[1][2*TW +: TW] = 10'h155;
      wait_grant(1, 4'b0100, id);
      chk(1, "t3_grant_id", id, 2);
      tick(); rv[1] = '0;
      tick();
      for (int n = 1; n <= 8; n++) begin
         chk(1, "t3_abort_cycle", eab[1], (n == 8));
         tick();
      end
      chk(1, "t3_rsp_valid", rsv[1], 1);
      chk(1, "t3_rsp_id", rid[1], 2);
      chk(1, "t3_rsp_tape", rtp[1], 10'h155);
      chk(1, "t3_rsp_timeout", rto[1], 1);
      tick();
      chk(1, "t3_jobs_aborted", ja[1], 1);
      chk(1, "t3_model_aborted", m_abt[1], 1);

      // Halt in the same cycle the timeout would fire
      rv[1] = 4'b1000;
      rt[1][3*TW +: TW] = 10'h0AA;
      wait_grant(1, 4'b1000, id);
      chk(1, "t4_grant_id", id, 3);
      tick(); rv[1] = '0;
      tick();
      tick(7);
      hl[1] = 1'b1; res[1] = 10'h3FF;
      #1;
      chk(1, "t4_no_abort", eab[1], 0);
      tick(); hl[1] = 1'b0;
      chk(1, "t4_rsp_tape", rtp[1], 10'h3FF);
      chk(1, "t4_rsp_timeout", rto[1], 0);
      tick();
      chk(1, "t4_jobs_done", jd[1], 2);
      chk(1, "t4_jobs_aborted", ja[1], 1);

      // Response backpressure for 5 cycles with other requesters waiting
      rr[0] = 1'b0;
      rv[0] = 4'b0010;
      rt[0][1*TW +: TW] = 10'h2C3;
      rt[0][2*TW +: TW] = 10'h0F0;
      wait_grant(0, 4'b0010, id);
      chk(0, "t5_grant_id", id, 1);
      tick(); rv[0] = 4'b1111;
      tick(2);
      hl[0] = 1'b1; res[0] = 10'h1E1;
      tick(); hl[0] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk(0, "t5_hold_valid", rsv[0], 1);
         chk(0, "t5_hold_tape", rtp[0], 10'h1E1);
         chk(0, "t5_hold_id", rid[0], 1);
         chk(0, "t5_no_grant", rdy[0], 0);
         tick();
      end
      rr[0] = 1'b1;
      tick();
      chk(0, "t5_next_grant", rdy[0], 4'b0100);
      chk(0, "t5_jobs_done", jd[0], 6);

      // Reset in the middle of requester 2's run, then a spurious halt
      tick(); rv[0] = '0;
      tick(4);
      rst = 1'b1;
      #1;
      chk(0, "t6_eng_load", eld[0], 0);
      chk(0, "t6_eng_tape", etp[0], 0);
      chk(0, "t6_eng_abort", eab[0], 0);
      chk(0, "t6_rsp_valid", rsv[0], 0);
      chk(0, "t6_rsp_tape", rtp[0], 0);
      chk(0, "t6_jobs_done", jd[0], 0);
      chk(0, "t6_jobs_aborted", ja[0], 0);
      chk(1, "t6_other_jobs_done", jd[1], 0);
      tick(); rst = 1'b0;
      hl[0] = 1'b1; res[0] = 10'h077;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk(0, "t6_spurious_halt", rsv[0], 0);
      end
      hl[0] = 1'b0;
      rv[0] = 4'b1111;
      #1;
      chk(0, "t6_first_grant", rdy[0], 4'b0001);
      tick(); rv[0] = '0;
      tick();
      hl[0] = 1'b1; res[0] = 10'h123;
      tick(); hl[0] = 1'b0;
      chk(0, "t6_rsp_id", rid[0], 0);
      chk(0, "t6_rsp_tape_after", rtp[0], 10'h123);
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
